// File: rtl/computer_mc.sv
// Multi-cycle accumulator computer: A/B registers, ALU with {Z,N,C,V}, loadable
// instruction memory and data memory, sequenced FETCH -> EXEC -> (MEM) with run/halt control.
module computer_mc #(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int OPW = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [OPW+DW-1:0] prog_data,
    output logic [AW-1:0]     pc,
    output logic [DW-1:0]     reg_a,
    output logic [DW-1:0]     reg_b,
    output logic [DW-1:0]     alu_out,
    output logic [3:0]        flags,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);
    localparam int IW    = OPW + DW;
    localparam int DEPTH = 1 << AW;

    localparam logic [OPW-1:0] OP_LDA = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_LDB = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_MOV = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_ADD = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_SUB = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_AND = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_OR  = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_XOR = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_LD  = OPW'(8'h09);
    localparam logic [OPW-1:0] OP_ST  = OPW'(8'h0A);
    localparam logic [OPW-1:0] OP_JMP = OPW'(8'h0B);
    localparam logic [OPW-1:0] OP_JEQ = OPW'(8'h0C);
    localparam logic [OPW-1:0] OP_JNE = OPW'(8'h0D);
    localparam logic [OPW-1:0] OP_JCS = OPW'(8'h0E);
    localparam logic [OPW-1:0] OP_CMP = OPW'(8'h0F);
    localparam logic [OPW-1:0] OP_HLT = '1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ir;
    logic [IW-1:0]   imem [DEPTH];
    logic [DW-1:0]   dmem [DEPTH];

    logic [OPW-1:0]  op;
    logic [DW-1:0]   k;
    logic            is_mem, op_known, jump;
    logic            alu_en, alu_c, alu_v;
    logic [DW-1:0]   alu_res;
    logic [DW:0]     sum, diff;

    assign op       = ir[IW-1:DW];
    assign k        = ir[DW-1:0];
    assign is_mem   = (op == OP_LD) || (op == OP_ST);
    assign op_known = (op < OPW'(16)) || (op == OP_HLT);
    assign busy     = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign halted   = (state == S_HALT);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_en  = 1'b0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum     = {1'b0, reg_a} + {1'b0, reg_b};
        diff    = {1'b0, reg_a} - {1'b0, reg_b};
        case (op)
            OP_ADD: begin
                alu_en  = 1'b1;
                alu_res = sum[DW-1:0];
                alu_c   = sum[DW];
                alu_v   = (reg_a[DW-1] == reg_b[DW-1]) && (alu_res[DW-1] != reg_a[DW-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_en  = 1'b1;
                alu_res = diff[DW-1:0];
                alu_c   = diff[DW];  // borrow: A < B unsigned
                alu_v   = (reg_a[DW-1] != reg_b[DW-1]) && (alu_res[DW-1] != reg_a[DW-1]);
            end
            OP_AND: begin alu_en = 1'b1; alu_res = reg_a & reg_b; end
            OP_OR:  begin alu_en = 1'b1; alu_res = reg_a | reg_b; end
            OP_XOR: begin alu_en = 1'b1; alu_res = reg_a ^ reg_b; end
            default: ;
        endcase
    end

    // Conditional jumps look at the flags registered before this EXEC.
    always_comb begin
        jump = 1'b0;
        case (op)
            OP_JMP:  jump = 1'b1;
            OP_JEQ:  jump = flags[3];
            OP_JNE:  jump = !flags[3];
            OP_JCS:  jump = flags[1];
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_n = S_FETCH;
            S_FETCH:        state_n = S_EXEC;
            S_EXEC: begin
                if (is_mem)             state_n = S_MEM;
                else if (op == OP_HLT)  state_n = S_HALT;
                else                    state_n = S_FETCH;
            end
            S_MEM:          state_n = S_FETCH;
            default:        state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            alu_out <= '0;
            flags   <= '0;
            illegal <= 1'b0;
            ir      <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc      <= '0;
                        illegal <= 1'b0;
                    end
                end
                S_FETCH: ir <= imem[pc];
                S_EXEC: begin
                    if (!op_known) illegal <= 1'b1;
                    if (alu_en) begin
                        alu_out <= alu_res;
                        flags   <= {alu_res == '0, alu_res[DW-1], alu_c, alu_v};
                        if (op != OP_CMP) reg_a <= alu_res;
                    end
                    case (op)
                        OP_LDA:  reg_a <= k;
                        OP_LDB:  reg_b <= k;
                        OP_MOV:  reg_a <= reg_b;
                        default: ;
                    endcase
                    if (!is_mem) pc <= jump ? AW'(k) : pc + AW'(1);
                end
                S_MEM: begin
                    if (op == OP_LD) reg_a <= dmem[AW'(k)];
                    pc <= pc + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: memory arrays carry no reset; only the store is gated so a reset landing in MEM aborts it.
    always_ff @(posedge clk) begin
        if (prog_we) imem[prog_addr] <= prog_data;
        if (!rst && state == S_MEM && op == OP_ST) dmem[AW'(k)] <= reg_a;
    end
endmodule

// File: tb/tb_computer_mc.sv
// Bench for computer_mc: ALU vector table, directed multi-cycle sequences, and random
// programs compared against an instruction-level reference model.
module tb_computer_mc;
    localparam int DW = 8, AW = 8, OPW = 7, IW = OPW + DW, DEPTH = 1 << AW;
    localparam int FULL = 1 << DW, HALF = FULL / 2;

    logic              clk = 1'b0;
    logic              rst, start, prog_we;
    logic [AW-1:0]     prog_addr;
    logic [IW-1:0]     prog_data;
    logic [AW-1:0]     pc;
    logic [DW-1:0]     reg_a, reg_b, alu_out;
    logic [3:0]        flags;
    logic              busy, halted, illegal;

    computer_mc #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .pc(pc), .reg_a(reg_a), .reg_b(reg_b), .alu_out(alu_out),
        .flags(flags), .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic load(input int addr, input logic [7:0] op, input logic [7:0] kv);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = {op[OPW-1:0], kv};
        step();
        prog_we   = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        check({name, "_halt"}, 32'(halted), 1);
    endtask

    // Instruction-level reference model
    logic [IW-1:0] m_imem [DEPTH];
    int m_dmem [DEPTH];
    int m_a, m_b, m_alu, m_flags, m_pc, m_ill, m_halt;

    function automatic int to_signed(input int x);
        return (x >= HALF) ? x - FULL : x;
    endfunction

    function automatic void model_alu(input int op);
        int r, sr;
        bit c, v;
        r = 0; sr = 0; c = 0; v = 0;
        case (op)
            4: begin
                r  = m_a + m_b;
                c  = r >= FULL;
                sr = to_signed(m_a) + to_signed(m_b);
                v  = sr >= HALF || sr < -HALF;
            end
            5, 15: begin
                r  = m_a - m_b + FULL;
                c  = m_a < m_b;
                sr = to_signed(m_a) - to_signed(m_b);
                v  = sr >= HALF || sr < -HALF;
            end
            6: r = m_a & m_b;
            7: r = m_a | m_b;
            8: r = m_a ^ m_b;
            default: ;
        endcase
        r       = r % FULL;
        m_alu   = r;
        m_flags = ((r == 0) ? 8 : 0) + ((r >= HALF) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
        if (op != 15) m_a = r;
    endfunction

    task automatic model_run(input int max_instr, output int cycles);
        int op, kv, nxt;
        cycles = 0; m_pc = 0; m_ill = 0; m_halt = 0;
        for (int n = 0; n < max_instr && m_halt == 0; n++) begin
            op  = int'(m_imem[m_pc][IW-1:DW]);
            kv  = int'(m_imem[m_pc][DW-1:0]);
            nxt = (m_pc + 1) % DEPTH;
            cycles += 2;
            case (op)
                0: ;
                1: m_a = kv;
                2: m_b = kv;
                3: m_a = m_b;
                4, 5, 6, 7, 8, 15: model_alu(op);
                9:  begin m_a = m_dmem[kv % DEPTH]; cycles++; end
                10: begin m_dmem[kv % DEPTH] = m_a; cycles++; end
                11: nxt = kv % DEPTH;
                12: if ((m_flags & 8) != 0) nxt = kv % DEPTH;
                13: if ((m_flags & 8) == 0) nxt = kv % DEPTH;
                14: if ((m_flags & 2) != 0) nxt = kv % DEPTH;
                127: m_halt = 1;
                default: m_ill = 1;
            endcase
            m_pc = nxt;
        end
    endtask

    function automatic logic [IW-1:0] rand_instr();
        int r, op, kv;
        r  = $urandom_range(0, 99);
        kv = $urandom_range(0, FULL - 1);
        if (r < 3)      op = 127;
        else if (r < 6) op = $urandom_range(16, 126);
        else            op = $urandom_range(0, 15);
        if (op == 9 || op == 10) kv = 240 + $urandom_range(0, 15);
        return {op[OPW-1:0], kv[DW-1:0]};
    endfunction

    typedef struct {
        logic [7:0] op, a, b, exp_a, exp_alu;
        logic [3:0] exp_f;
    } alu_vec_t;

    alu_vec_t vecs [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int v;
        vecs[0] = '{8'h04, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1010};
        vecs[1] = '{8'h05, 8'h80, 8'h01, 8'h7F, 8'h7F, 4'b0001};
        vecs[2] = '{8'h0F, 8'h01, 8'h02, 8'h01, 8'hFF, 4'b0110};
        vecs[3] = '{8'h04, 8'h7F, 8'h01, 8'h80, 8'h80, 4'b0101};
        vecs[4] = '{8'h04, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1011};
        vecs[5] = '{8'h05, 8'h05, 8'h05, 8'h00, 8'h00, 4'b1000};
        vecs[6] = '{8'h06, 8'hF0, 8'h3C, 8'h30, 8'h30, 4'b0000};
        vecs[7] = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1000};
        vecs[8] = '{8'h08, 8'hAA, 8'h55, 8'hFF, 8'hFF, 4'b0100};

        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        step(); step();
        rst = 1'b0;
        check("rst_pc", 32'(pc), 0);
        check("rst_a", 32'(reg_a), 0);
        check("rst_b", 32'(reg_b), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);

        // ALU vector table
        for (int i = 0; i < 9; i++) begin
            load(0, 8'h01, vecs[i].a);
            load(1, 8'h02, vecs[i].b);
            load(2, vecs[i].op, 8'h00);
            load(3, 8'h7F, 8'h00);
            pulse_start();
            wait_halt(20, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_a", i), 32'(reg_a), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d_alu", i), 32'(alu_out), 32'(vecs[i].exp_alu));
            check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_f));
        end

        // Exact latency: halted appears on the 9th edge counting the start edge
        load(0, 8'h01, 8'hFF); load(1, 8'h02, 8'h01); load(2, 8'h04, 8'h00); load(3, 8'h7F, 8'h00);
        pulse_start();
        check("lat_halted_after_start", 32'(halted), 0);
        repeat (7) step();
        check("lat_busy_edge8", 32'(busy), 1);
        check("lat_halted_edge8", 32'(halted), 0);
        step();
        check("lat_halted_edge9", 32'(halted), 1);

        // Memory path with per-instruction pc timing
        load(0, 8'h01, 8'h5A); load(1, 8'h0A, 8'h10); load(2, 8'h01, 8'h00);
        load(3, 8'h09, 8'h10); load(4, 8'h7F, 8'h00);
        pulse_start();
        repeat (4) step();
        check("mem_pc_in_st_mem", 32'(pc), 1);
        step();
        check("mem_pc_after_st", 32'(pc), 2);
        repeat (4) step();
        check("mem_a_before_ld_mem", 32'(reg_a), 0);
        step();
        check("mem_a_after_ld", 32'(reg_a), 'h5A);
        check("mem_pc_after_ld", 32'(pc), 4);
        step();
        check("mem_halted_edge12", 32'(halted), 0);
        step();
        check("mem_halted_edge13", 32'(halted), 1);

        // Countdown loop: three SUB/JNE iterations, halts on edge 19
        load(0, 8'h01, 8'h03); load(1, 8'h02, 8'h01); load(2, 8'h05, 8'h00);
        load(3, 8'h0D, 8'h02); load(4, 8'h7F, 8'h00);
        pulse_start();
        repeat (17) step();
        check("loop_halted_edge18", 32'(halted), 0);
        step();
        check("loop_halted_edge19", 32'(halted), 1);
        check("loop_a", 32'(reg_a), 0);
        check("loop_flags", 32'(flags), 'b1000);

        // JMP to last address then NOP wraps pc to 0
        load(0, 8'h0B, 8'hFF); load(255, 8'h00, 8'h00);
        pulse_start();
        step(); step();
        check("jmp_pc_ff", 32'(pc), 'hFF);
        step(); step();
        check("jmp_pc_wrap", 32'(pc), 0);
        do_reset();

        // Illegal opcode, restart from HALT, start ignored while busy
        load(0, 8'h01, 8'hF0); load(1, 8'h02, 8'h20); load(2, 8'h04, 8'h00);
        load(3, 8'h55, 8'h00); load(4, 8'h03, 8'h00); load(5, 8'h7F, 8'h00);
        pulse_start();
        repeat (6) step();
        check("ill_before", 32'(illegal), 0);
        step(); step();
        check("ill_set", 32'(illegal), 1);
        check("ill_a", 32'(reg_a), 'h10);
        check("ill_b", 32'(reg_b), 'h20);
        check("ill_flags", 32'(flags), 'b0010);
        check("ill_pc", 32'(pc), 4);
        wait_halt(20, "ill");
        check("ill_continue_a", 32'(reg_a), 'h20);
        check("ill_sticky", 32'(illegal), 1);
        pulse_start();
        check("restart_illegal", 32'(illegal), 0);
        check("restart_pc", 32'(pc), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_halted", 32'(halted), 0);
        repeat (4) step();
        pulse_start();
        check("busy_start_ignored_pc", 32'(pc), 2);
        wait_halt(20, "restart");

        // Fetch collision returns old word; writes during run affect later fetches
        load(0, 8'h01, 8'hAA); load(1, 8'h7F, 8'h00);
        pulse_start();
        prog_we = 1'b1; prog_addr = 8'h00; prog_data = {7'h01, 8'hBB};
        step();
        prog_addr = 8'h01; prog_data = {7'h02, 8'hCC};
        step();
        check("coll_old_word_a", 32'(reg_a), 'hAA);
        prog_addr = 8'h02; prog_data = {7'h7F, 8'h00};
        step();
        prog_we = 1'b0;
        wait_halt(20, "coll");
        check("run_write_b", 32'(reg_b), 'hCC);
        pulse_start();
        wait_halt(20, "coll_rerun");
        check("coll_new_word_a", 32'(reg_a), 'hBB);

        // Reset landing in MEM of a store aborts the write
        load(0, 8'h01, 8'h33); load(1, 8'h0A, 8'h20); load(2, 8'h7F, 8'h00);
        pulse_start();
        wait_halt(20, "pre_store");
        load(0, 8'h01, 8'h77); load(1, 8'h02, 8'h88); load(2, 8'h0F, 8'h00);
        load(3, 8'h0A, 8'h20); load(4, 8'h7F, 8'h00);
        pulse_start();
        repeat (8) step();
        check("rmem_busy", 32'(busy), 1);
        check("rmem_flags_before", 32'(flags), 'b0111);
        do_reset();
        check("rmem_pc", 32'(pc), 0);
        check("rmem_a", 32'(reg_a), 0);
        check("rmem_b", 32'(reg_b), 0);
        check("rmem_alu", 32'(alu_out), 0);
        check("rmem_flags", 32'(flags), 0);
        check("rmem_busy_after", 32'(busy), 0);
        check("rmem_halted", 32'(halted), 0);
        load(0, 8'h09, 8'h20); load(1, 8'h7F, 8'h00);
        pulse_start();
        wait_halt(20, "rmem_ld");
        check("rmem_no_write", 32'(reg_a), 'h33);

        // Prime data memory F0..FF with known values for random programs
        for (int i = 0; i < 16; i++) begin
            v = $urandom_range(0, FULL - 1);
            m_dmem[240 + i] = v;
            load(2 * i, 8'h01, v[7:0]);
            load(2 * i + 1, 8'h0A, 8'(240 + i));
        end
        load(32, 8'h7F, 8'h00);
        pulse_start();
        wait_halt(200, "prime");

        // Random programs vs reference model
        for (int t = 0; t < 12; t++) begin
            do_reset();
            for (int a = 0; a < DEPTH; a++) begin
                m_imem[a] = rand_instr();
                load(a, {1'b0, m_imem[a][IW-1:DW]}, m_imem[a][DW-1:0]);
            end
            m_a = 0; m_b = 0; m_alu = 0; m_flags = 0;
            model_run(40, cyc);
            pulse_start();
            repeat (cyc) step();
            check($sformatf("rnd%0d_a", t), 32'(reg_a), 32'(m_a));
            check($sformatf("rnd%0d_b", t), 32'(reg_b), 32'(m_b));
            check($sformatf("rnd%0d_alu", t), 32'(alu_out), 32'(m_alu));
            check($sformatf("rnd%0d_flags", t), 32'(flags), 32'(m_flags));
            check($sformatf("rnd%0d_illegal", t), 32'(illegal), 32'(m_ill));
            check($sformatf("rnd%0d_halted", t), 32'(halted), 32'(m_halt));
            check($sformatf("rnd%0d_busy", t), 32'(busy), (m_halt != 0) ? 0 : 1);
            if (m_halt == 0) check($sformatf("rnd%0d_pc", t), 32'(pc), 32'(m_pc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
